multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: HALT_OP, default 6'b111111, opcode that stops the machine.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26] of the current instruction.
REQ-005 funct  input  6  IR[5:0]; used only when opcode = 000000.
REQ-006 zero  input  1  ALU zero flag; sampled in EXE_BR.
REQ-007 PCWre, IRWre, RegWre, mRD, mWR  output  1 each  write/read strobes.
REQ-008 ALUSrcA, ALUSrcB, DBDataSrc, RegDst, ExtSel  output  1 each  select lines for downstream 2:1 32-bit selectors (0 = first input).
REQ-009 PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-010 ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-011 state  output  3  current state encoding, for debug.

Function
REQ-012 States and encodings: IF 000, ID 001, EXE_AL 110, EXE_BR 101, EXE_LS 010, MEM 011, WB_AL 111, WB_LD 100; one extra HALT state is held by a separate sticky flag. state reads 001 while halted.
REQ-013 Transitions: IF->ID always. In ID: j or HALT_OP or unknown opcode -> IF or HALT; beq -> EXE_BR; lw/sw -> EXE_LS; R-type/addi/ori -> EXE_AL. EXE_AL->WB_AL->IF. EXE_BR->IF. EXE_LS->MEM. MEM: lw->WB_LD->IF, sw->IF.
REQ-014 Decoded opcodes: R-type 000000, addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010. All other opcodes except HALT_OP are treated as nop.
REQ-015 R-type funct mapping: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct behaves as add with RegWre forced to 0 in WB_AL.
REQ-016 IRWre = 1 only in IF. mRD = 1 only in MEM for lw. mWR = 1 only in MEM for sw.
REQ-017 PCWre = 1 in exactly one cycle per instruction, that instruction's final cycle: WB_AL, WB_LD, EXE_BR, MEM(sw), or ID(j/nop).
REQ-018 PCSrc = 10 in ID for j. In EXE_BR, PCSrc = 01 when zero = 1 and 00 otherwise. All other cycles use 00.
REQ-019 RegWre = 1 only in WB_AL and WB_LD.
REQ-020 RegDst = 1 for R-type. DBDataSrc = 1 in WB_LD. ALUSrcB = 1 for addi/ori/lw/sw. ExtSel = 0 for ori, 1 otherwise. ALUSrcA = 0.
REQ-021 ALUOp: add for addi/lw/sw, or for ori, sub for beq; R-type per REQ-015.
REQ-022 Outputs are combinational from registered state and opcode/funct. No output changes between edges except when opcode, funct or zero change.
REQ-023 Throughput: j/nop 2 cycles; beq 3; R/addi/ori/sw 4; lw 5.
REQ-024 HALT_OP decoded in ID sets the halt flag. While halted, all strobes (PCWre, IRWre, RegWre, mRD, mWR) are 0 and the state is frozen until Reset.

Reset
REQ-025 Reset = 1 at a rising edge forces state = IF and clears the halt flag, regardless of current state, including mid-instruction.
REQ-026 While Reset = 1, all strobes are 0, PCSrc = 00, ALUOp = 000, and all selects are 0. The first IF cycle begins on the edge after Reset falls.

Structure
REQ-027 State encodings, opcode/funct constants and ALUOp codes live in a shared include, control_defs.vh, which the ALU and datapath also use.
REQ-028 Natural split: sub-module control_decode, pure combinational decode of (state, opcode, funct, zero) to outputs. The top holds only the state register and the halt flag.

Verification
REQ-029 add (op 000000, funct 100000) after Reset -> states 000,001,110,111,000; RegWre = 1 and RegDst = 1 only in 111; PCWre = 1 only in 111.
REQ-030 lw (100011) -> 000,001,010,011,100; mRD = 1 in 011; DBDataSrc = 1 and RegWre = 1 in 100; ALUOp = 000 and ALUSrcB = 1 in 010.
REQ-031 beq (000100) with zero = 1 -> PCSrc = 01 and PCWre = 1 in 101. Repeat with zero = 0 -> PCSrc = 00.
REQ-032 j (000010) -> PCSrc = 10 and PCWre = 1 in ID; next state is 000.
REQ-033 opcode 111111 -> after ID, all strobes stay 0 for 20 cycles. Reset pulse -> state returns to 000.
REQ-034 Reset asserted during MEM of sw -> mWR = 0 in that cycle; state = 000 at the next edge; no PCWre pulse occurs.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcode/funct constants, ALU operation codes, PC source codes and the
// packed control-word layout passed from the decoder to the top.
package multi_cycle_control_pkg;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_LD  = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic       m_rd;
    logic       m_wr;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       db_data_src;
    logic       reg_dst;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // R-type funct codes the ALU actually implements.
  function automatic logic funct_known(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational decode of (state, opcode, funct, zero) into the control
// word and the next state.
//   state_i      current FSM state
//   opcode_i     IR[31:26]
//   funct_i      IR[5:0], only meaningful for R-type
//   zero_i       ALU zero flag, only looked at in EXE_BR
//   active_i     low while in reset or halted: forces an all-zero control word
//   ctrl_o       control word
//   next_state_o state to load at the next edge
//   halt_set_o   HALT_OP seen in ID
module control_decode
  import multi_cycle_control_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       active_i,
  output ctrl_t      ctrl_o,
  output state_e     next_state_o,
  output logic       halt_set_o
);

  logic       is_halt, is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j;
  logic [2:0] alu_op;

  // HALT_OP is checked first so an overridden value always wins.
  assign is_halt = (opcode_i == HALT_OP);
  assign is_r    = !is_halt && (opcode_i == OP_RTYPE);
  assign is_addi = !is_halt && (opcode_i == OP_ADDI);
  assign is_ori  = !is_halt && (opcode_i == OP_ORI);
  assign is_lw   = !is_halt && (opcode_i == OP_LW);
  assign is_sw   = !is_halt && (opcode_i == OP_SW);
  assign is_beq  = !is_halt && (opcode_i == OP_BEQ);
  assign is_j    = !is_halt && (opcode_i == OP_J);

  always_comb begin
    alu_op = ALU_ADD;
    if (is_r) begin
      case (funct_i)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (is_ori) begin
      alu_op = ALU_OR;
    end else if (is_beq) begin
      alu_op = ALU_SUB;
    end
  end

  always_comb begin
    ctrl_o       = '0;
    next_state_o = ST_IF;
    halt_set_o   = 1'b0;
    if (active_i) begin
      ctrl_o.alu_op    = alu_op;
      ctrl_o.alu_src_b = is_addi || is_ori || is_lw || is_sw;
      ctrl_o.ext_sel   = !is_ori;
      case (state_i)
        ST_IF: begin
          ctrl_o.ir_wre = 1'b1;
          next_state_o  = ST_ID;
        end
        ST_ID: begin
          if (is_halt) begin
            halt_set_o   = 1'b1;
            next_state_o = ST_ID;
          end else if (is_j) begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PC_JMP;
          end else if (is_beq) begin
            next_state_o = ST_EXE_BR;
          end else if (is_lw || is_sw) begin
            next_state_o = ST_EXE_LS;
          end else if (is_r || is_addi || is_ori) begin
            next_state_o = ST_EXE_AL;
          end else begin
            // Unknown opcode: a nop that retires in ID.
            ctrl_o.pc_wre = 1'b1;
          end
        end
        ST_EXE_AL: next_state_o = ST_WB_AL;
        ST_WB_AL: begin
          // Unsupported R-type funct still runs as add but must not write back.
          ctrl_o.reg_wre = !(is_r && !funct_known(funct_i));
          ctrl_o.reg_dst = is_r;
          ctrl_o.pc_wre  = 1'b1;
        end
        ST_EXE_BR: begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = zero_i ? PC_BR : PC_SEQ;
        end
        ST_EXE_LS: next_state_o = ST_MEM;
        ST_MEM: begin
          if (is_lw) begin
            ctrl_o.m_rd  = 1'b1;
            next_state_o = ST_WB_LD;
          end else begin
            // sw retires here; any other opcode also retires so PC still moves.
            ctrl_o.m_wr   = is_sw;
            ctrl_o.pc_wre = 1'b1;
          end
        end
        ST_WB_LD: begin
          ctrl_o.reg_wre     = 1'b1;
          ctrl_o.db_data_src = 1'b1;
          ctrl_o.pc_wre      = 1'b1;
        end
        default: next_state_o = ST_IF;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle processor control unit. Holds the state register and the sticky
// halt flag; all output decoding lives in control_decode.
//   CLK, Reset        clock and synchronous active-high reset
//   opcode, funct     instruction fields, zero = ALU zero flag
//   PCWre..mWR        write/read strobes
//   ALUSrcA..ExtSel   2:1 selector controls
//   PCSrc, ALUOp      PC source and ALU operation
//   state             current state (reads ID while halted)
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       RegDst,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  state_e state_q, state_d, next_state;
  logic   halt_q, halt_d, halt_set;
  ctrl_t  ctrl;

  control_decode #(.HALT_OP(HALT_OP)) u_decode (
    .state_i      (state_q),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .zero_i       (zero),
    .active_i     (!Reset && !halt_q),
    .ctrl_o       (ctrl),
    .next_state_o (next_state),
    .halt_set_o   (halt_set)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IF;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Once halted, state and flag stay frozen until Reset.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      state_d = next_state;
      halt_d  = halt_set;
    end
  end

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign RegWre    = ctrl.reg_wre;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign DBDataSrc = ctrl.db_data_src;
  assign RegDst    = ctrl.reg_dst;
  assign ExtSel    = ctrl.ext_sel;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ctrl.alu_op;
  assign state     = state_q;

endmodule
